// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the CPU phase sequencer: parameter defaults and the
// 2-bit phase codes that ControlUnit decodes.
package cpu_sequencer_pkg;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_PM_DEPTH = 256;
    localparam int DEF_INS_W    = 12;
    localparam int DEF_CNT_W    = 16;

    typedef enum logic [1:0] {
        PH_LOAD    = 2'b00,
        PH_FETCH   = 2'b01,
        PH_DECODE  = 2'b10,
        PH_EXECUTE = 2'b11
    } cu_phase_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Program-load stream between the loader, the sequencer and program memory.
// ld_data bypasses the sequencer; memory writes it when ld_wr is high.
interface cpu_sequencer_if
    import cpu_sequencer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INS_W  = DEF_INS_W
);
    logic              ld_valid;
    logic [INS_W-1:0]  ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_wr;
    logic [ADDR_W-1:0] ld_addr;

    modport master (output ld_valid, ld_data, ld_last, input ld_ready, ld_wr, ld_addr);
    modport slave  (input ld_valid, ld_last, output ld_ready, ld_wr, ld_addr);
    modport pm     (input ld_wr, ld_addr, ld_data);
endinterface

// File: rtl/cpu_sequencer_load_addr_counter.sv
// Program-memory write address counter with clear, increment and a
// terminal-count flag on the last loadable address.
module cpu_sequencer_load_addr_counter #(
    parameter int ADDR_W   = 8,
    parameter int PM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            addr <= '0;
        else if (clr)
            addr <= '0;
        else if (inc)
            addr <= addr + 1'b1;
    end

    assign tc = (addr == ADDR_W'(PM_DEPTH - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Master phase sequencer: program load over a valid/ready stream, then the
// FETCH->DECODE->EXECUTE cycle with halt, single-step and resume.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int PM_DEPTH = DEF_PM_DEPTH,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    cpu_sequencer_if.slave   ld,
    input  logic             start,
    output logic [1:0]       state,
    output logic             cpu_en,
    input  logic             halt_req,
    input  logic             step,
    input  logic             resume,
    output logic             halted,
    output logic             load_done,
    output logic             load_trunc,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic [2:0] fsm;
    logic       step_pend;
    logic       halt_pend;
    logic       start_ok;
    logic       accept;
    logic       ctr_inc;
    logic       ctr_tc;

    assign start_ok    = start & ((fsm == S_IDLE) | (fsm == S_HALT));
    assign ld.ld_ready = (fsm == S_LOAD);
    assign accept      = ld.ld_valid & ld.ld_ready;
    assign ld.ld_wr    = accept;
    // The address freezes on the final word so it still names it after the load.
    assign ctr_inc     = accept & ~ld.ld_last & ~ctr_tc;

    cpu_sequencer_load_addr_counter #(
        .ADDR_W   (ADDR_W),
        .PM_DEPTH (PM_DEPTH)
    ) u_addr_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .inc   (ctr_inc),
        .addr  (ld.ld_addr),
        .tc    (ctr_tc)
    );

    always_comb begin
        state = PH_LOAD;
        case (fsm)
            S_FETCH:  state = PH_FETCH;
            S_DECODE: state = PH_DECODE;
            S_EXEC:   state = PH_EXECUTE;
            default:  state = PH_LOAD;
        endcase
    end

    assign cpu_en = (fsm == S_FETCH) | (fsm == S_DECODE) | (fsm == S_EXEC);
    assign halted = (fsm == S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= S_IDLE;
            step_pend   <= 1'b0;
            halt_pend   <= 1'b0;
            load_done   <= 1'b0;
            load_trunc  <= 1'b0;
            instr_count <= '0;
        end else if (start_ok) begin
            fsm         <= S_LOAD;
            step_pend   <= 1'b0;
            halt_pend   <= 1'b0;
            load_done   <= 1'b0;
            load_trunc  <= 1'b0;
            instr_count <= '0;
        end else begin
            case (fsm)
                S_LOAD: begin
                    if (accept && (ld.ld_last || ctr_tc)) begin
                        fsm       <= S_FETCH;
                        load_done <= 1'b1;
                        if (!ld.ld_last)
                            load_trunc <= 1'b1;
                    end
                end
                // A halt request seen mid-instruction is held until EXEC retires it.
                S_FETCH: begin
                    fsm <= S_DECODE;
                    if (halt_req)
                        halt_pend <= 1'b1;
                end
                S_DECODE: begin
                    fsm <= S_EXEC;
                    if (halt_req)
                        halt_pend <= 1'b1;
                end
                S_EXEC: begin
                    instr_count <= instr_count + 1'b1;
                    if (halt_req || halt_pend || step_pend) begin
                        fsm       <= S_HALT;
                        halt_pend <= 1'b0;
                        step_pend <= 1'b0;
                    end else begin
                        fsm <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (resume) begin
                        fsm       <= S_FETCH;
                        step_pend <= 1'b0;
                    end else if (step) begin
                        fsm       <= S_FETCH;
                        step_pend <= 1'b1;
                    end
                end
                S_IDLE:  fsm <= S_IDLE;
                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed vector table, hand sequences for
// truncation and async reset, then random stimulus against a phase-level model.
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    localparam int ADDR_W   = 8;
    localparam int PM_DEPTH = 4;
    localparam int CNT_W    = 16;
    localparam int MM_IDLE  = 0;
    localparam int MM_LOAD  = 1;
    localparam int MM_RUN   = 2;
    localparam int MM_HALT  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, halt_req = 1'b0, step = 1'b0, resume = 1'b0;
    logic [1:0] state;
    logic cpu_en, halted, load_done, load_trunc;
    logic [CNT_W-1:0] instr_count;

    cpu_sequencer_if #(.ADDR_W(ADDR_W), .INS_W(12)) bus();

    cpu_sequencer #(.ADDR_W(ADDR_W), .PM_DEPTH(PM_DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld          (bus),
        .start       (start),
        .state       (state),
        .cpu_en      (cpu_en),
        .halt_req    (halt_req),
        .step        (step),
        .resume      (resume),
        .halted      (halted),
        .load_done   (load_done),
        .load_trunc  (load_trunc),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    // Model: mode, position inside the instruction, words accepted so far.
    int m_mode, m_pos, m_words, m_cnt;
    bit m_done, m_trunc, m_single, m_hpend;

    typedef struct {
        logic st, v, l, h, s, r;
        logic [1:0] state;
        logic en, rdy;
        logic [7:0] addr;
        logic hlt, done, trunc;
        logic [15:0] cnt;
    } row_t;
    row_t rows[23];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [30:0] dut_vec();
        return {state, cpu_en, bus.ld_ready, bus.ld_addr, halted, load_done, load_trunc, instr_count};
    endfunction

    function automatic logic [30:0] model_vec();
        logic [1:0] st;
        logic [7:0] a;
        st = (m_mode == MM_RUN) ? 2'(m_pos + 1) : 2'b00;
        if (m_words == 0)           a = 8'd0;
        else if (m_mode == MM_LOAD) a = 8'(m_words);
        else                        a = 8'(m_words - 1);
        return {st, 1'(m_mode == MM_RUN), 1'(m_mode == MM_LOAD), a, 1'(m_mode == MM_HALT),
                1'(m_done), 1'(m_trunc), 16'(m_cnt)};
    endfunction

    task automatic model_reset();
        m_mode = MM_IDLE; m_pos = 0; m_words = 0; m_cnt = 0;
        m_done = 0; m_trunc = 0; m_single = 0; m_hpend = 0;
    endtask

    task automatic model_begin_load();
        m_mode = MM_LOAD; m_words = 0; m_cnt = 0;
        m_done = 0; m_trunc = 0; m_single = 0; m_hpend = 0;
    endtask

    task automatic model_update(input bit st, input bit v, input bit l, input bit h,
                                input bit s, input bit r);
        if (m_mode == MM_IDLE) begin
            if (st) model_begin_load();
        end else if (m_mode == MM_LOAD) begin
            if (v) begin
                m_words++;
                if (l || m_words == PM_DEPTH) begin
                    m_mode = MM_RUN; m_pos = 0; m_done = 1;
                    if (!l) m_trunc = 1;
                end
            end
        end else if (m_mode == MM_RUN) begin
            if (h) m_hpend = 1;
            if (m_pos < 2) m_pos++;
            else begin
                m_cnt = (m_cnt + 1) % 65536;
                if (m_hpend || m_single) begin
                    m_mode = MM_HALT; m_hpend = 0; m_single = 0;
                end else m_pos = 0;
            end
        end else begin
            if (st) model_begin_load();
            else if (r) begin m_mode = MM_RUN; m_pos = 0; m_single = 0; end
            else if (s) begin m_mode = MM_RUN; m_pos = 0; m_single = 1; end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check("ld_wr", bus.ld_wr, bus.ld_valid & (m_mode == MM_LOAD));
        @(posedge clk);
        model_update(start, bus.ld_valid, bus.ld_last, halt_req, step, resume);
        #1;
        check("outputs", dut_vec(), model_vec());
    endtask

    task automatic drive(input bit st, input bit v, input bit l, input bit h, input bit s, input bit r);
        start = st; bus.ld_valid = v; bus.ld_last = l; halt_req = h; step = s; resume = r;
        bus.ld_data = 12'($urandom);
    endtask

    task automatic async_reset(input string name);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check(name, dut_vec(), 31'd0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rows[0]  = '{1,0,0,0,0,0, 2'd0,0,1,8'd0,0,0,0,16'd0};
        rows[1]  = '{0,1,0,0,0,0, 2'd0,0,1,8'd1,0,0,0,16'd0};
        rows[2]  = '{0,0,0,0,0,0, 2'd0,0,1,8'd1,0,0,0,16'd0};
        rows[3]  = '{0,1,0,0,0,0, 2'd0,0,1,8'd2,0,0,0,16'd0};
        rows[4]  = '{0,1,1,0,0,0, 2'd1,1,0,8'd2,0,1,0,16'd0};
        rows[5]  = '{0,0,0,0,0,0, 2'd2,1,0,8'd2,0,1,0,16'd0};
        rows[6]  = '{0,0,0,0,0,0, 2'd3,1,0,8'd2,0,1,0,16'd0};
        rows[7]  = '{0,0,0,0,0,0, 2'd1,1,0,8'd2,0,1,0,16'd1};
        rows[8]  = '{0,0,0,0,0,0, 2'd2,1,0,8'd2,0,1,0,16'd1};
        rows[9]  = '{0,0,0,1,0,0, 2'd3,1,0,8'd2,0,1,0,16'd1};
        rows[10] = '{0,0,0,0,0,0, 2'd0,0,0,8'd2,1,1,0,16'd2};
        rows[11] = '{0,0,0,1,0,0, 2'd0,0,0,8'd2,1,1,0,16'd2};
        rows[12] = '{0,0,0,0,1,0, 2'd1,1,0,8'd2,0,1,0,16'd2};
        rows[13] = '{0,0,0,0,0,0, 2'd2,1,0,8'd2,0,1,0,16'd2};
        rows[14] = '{0,0,0,0,0,0, 2'd3,1,0,8'd2,0,1,0,16'd2};
        rows[15] = '{0,0,0,0,0,0, 2'd0,0,0,8'd2,1,1,0,16'd3};
        rows[16] = '{0,0,0,0,1,1, 2'd1,1,0,8'd2,0,1,0,16'd3};
        rows[17] = '{0,0,0,0,0,0, 2'd2,1,0,8'd2,0,1,0,16'd3};
        rows[18] = '{0,0,0,0,0,0, 2'd3,1,0,8'd2,0,1,0,16'd3};
        rows[19] = '{0,0,0,0,0,0, 2'd1,1,0,8'd2,0,1,0,16'd4};
        rows[20] = '{0,0,0,0,1,0, 2'd2,1,0,8'd2,0,1,0,16'd4};
        rows[21] = '{1,0,0,0,0,0, 2'd3,1,0,8'd2,0,1,0,16'd4};
        rows[22] = '{0,0,0,0,0,0, 2'd1,1,0,8'd2,0,1,0,16'd5};

        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check("reset_state", dut_vec(), 31'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table: load 3 words with a gap, run, halt in DECODE, step, step+resume.
        foreach (rows[i]) begin
            drive(rows[i].st, rows[i].v, rows[i].l, rows[i].h, rows[i].s, rows[i].r);
            cycle();
            check($sformatf("row%0d", i), dut_vec(),
                  {rows[i].state, rows[i].en, rows[i].rdy, rows[i].addr, rows[i].hlt,
                   rows[i].done, rows[i].trunc, rows[i].cnt});
        end

        // Halt, then reload with 6 words and no ld_last into a 4-word memory.
        drive(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 10 && !halted; k++) cycle();
        check("halt_reached", halted, 1'b1);
        drive(1, 0, 0, 0, 0, 0);
        cycle();
        for (int w = 0; w < 6; w++) begin
            drive(0, 1, 0, 0, 0, 0);
            #3;
            check($sformatf("trunc_wr%0d", w), bus.ld_wr, (w < 4) ? 1'b1 : 1'b0);
            if (w < 4) check($sformatf("trunc_addr%0d", w), bus.ld_addr, 64'(w));
            cycle();
        end
        check("trunc_flags", {load_done, load_trunc, bus.ld_ready, bus.ld_addr}, {3'b110, 8'd3});

        // Async reset between edges, mid-EXEC then mid-LOAD.
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6 && state != 2'b11; k++) cycle();
        check("reach_exec", state, 2'b11);
        async_reset("reset_mid_exec");
        drive(1, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 1, 0, 0, 0, 0);
        cycle();
        check("load_addr_before_reset", bus.ld_addr, 8'd1);
        async_reset("reset_mid_load");
        drive(0, 0, 0, 0, 0, 0);
        cycle();

        for (int n = 0; n < 4000; n++) begin
            drive($urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 999) == 0) async_reset("random_reset");
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
